// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: two sram-like masters onto one sram-like slave with in-order ID FIFO routing (ARB_RR_EN selects round-robin)
module sram_like_arbiter #(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        arb_err
);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  typedef enum logic {FREE, LOCKED} lock_t;
  lock_t st, st_n;
  logic locked_id, grant, gnt_valid, gnt_req, accept, pop, head;
  logic [MAX_OUTST-1:0] id_fifo;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
`ifdef ARB_RR_EN
  logic last;
  // remember which master won the most recent handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b0;
    else if (accept) last <= grant;
`endif
  // lock state and the master held on the slave port while it stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= FREE;
      locked_id <= 1'b1;
    end else begin
      st <= st_n;
      if (s_req) locked_id <= grant;
    end
  // a request the slave refused keeps the port locked to its master
  always_comb st_n = (s_req & ~s_addr_ok) ? LOCKED : FREE;
  // grant select, request mux and response routing
  always_comb begin
`ifdef ARB_RR_EN
    grant = (st == LOCKED) ? locked_id : (m0_req & m1_req) ? ~last : m1_req;
`else
    grant = (st == LOCKED) ? locked_id : m1_req;
`endif
    gnt_valid = (st == LOCKED) | m0_req | m1_req;
    gnt_req = grant ? m1_req : m0_req;
    s_req = gnt_valid & gnt_req & (count < CW'(MAX_OUTST));
    s_wr = gnt_valid & (grant ? m1_wr : m0_wr);
    s_size = gnt_valid ? (grant ? m1_size : m0_size) : '0;
    s_addr = gnt_valid ? (grant ? m1_addr : m0_addr) : '0;
    s_wstrb = gnt_valid ? (grant ? m1_wstrb : m0_wstrb) : '0;
    s_wdata = gnt_valid ? (grant ? m1_wdata : m0_wdata) : '0;
    accept = s_req & s_addr_ok;
    m0_addr_ok = accept & ~grant;
    m1_addr_ok = accept & grant;
    pop = s_data_ok & (count != '0);
    head = id_fifo[rd_ptr];
    m0_data_ok = pop & ~head;
    m1_data_ok = pop & head;
    m0_rdata = m0_data_ok ? s_rdata : '0;
    m1_rdata = m1_data_ok ? s_rdata : '0;
  end
  // issuer ID FIFO, occupancy and sticky orphan-response flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_fifo <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      arb_err <= 1'b0;
    end else begin
      if (accept) begin
        id_fifo[wr_ptr] <= grant;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
      arb_err <= arb_err | (s_data_ok & (count == '0));
    end
endmodule
